putbits: RTL and testbench
==========================

Name: putbits

Overview:
- Encoder-side counterpart of getbits: packs variable-length codes (1–24 bits, MSB-first) into 64-bit words.
- Writes words into the downstream video output FIFO.
- Provides byte alignment (zero stuffing) and end-of-stream flush of a partial word.
- Sits between the VLC/header generator and the output bitstream FIFO.

Parameters:
WORD_W, 64, output word width; fixed at 64 and the only supported value
CODE_W, 24, maximum code length in bits
LEN_W, 5, width of the code-length field

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
clk_en  in  1  global clock enable; when low, all state holds and vid_out_wr_en=0
bits_in  in  CODE_W  code value, right-justified; bits above bits_len are ignored (masked)
bits_len  in  LEN_W  code length 0..24; values 25..31 saturate to 24
bits_valid  in  1  code present this cycle
bits_ready  out  1  block accepts a code/align/flush this cycle
align  in  1  pad zeros to next byte boundary; accepted when bits_ready
flush  in  1  align, then emit any partial word zero-padded; accepted when bits_ready
vid_out  out  WORD_W  packed word, first bit at bit 63
vid_out_wr_en  out  1  FIFO write strobe
vid_out_full  in  1  FIFO full
flush_done  out  1  one-cycle pulse when a flush completes
word_count  out  32  number of words written since reset; wraps at 2^32

Behaviour:
- Reset values: acc=0, cnt=0, out_word=0, out_pending=0, state=S_RUN, bits_ready=1, vid_out=0, vid_out_wr_en=0, flush_done=0, word_count=0. Reset mid-operation discards all buffered bits and any pending word.
- State: acc[63:0] accumulator, cnt 0..63 fill level, out_word/out_pending single-word staging register.
- bits_ready = clk_en & ~out_pending & (state==S_RUN).
- vid_out_wr_en = clk_en & out_pending & ~vid_out_full (combinational from registered state). vid_out = out_word.
- Write completion: at an edge with vid_out_wr_en=1, out_pending clears and word_count increments.

Accept on edge with bits_ready & bits_valid:
- Masked code is placed at acc[63-cnt -: len].
- If cnt+len < 64: cnt += len.
- If cnt+len >= 64: the upper 64 bits load out_word and out_pending sets. The remaining cnt+len-64 bits are left-aligned into acc (rest zero), and cnt = cnt+len-64.
- len=0: no-op.
- Latency: code accepted at edge N completes a word → vid_out_wr_en is high in cycle N+1 if not full.

Align (same edge, applied after any code):
- cnt is rounded up to a multiple of 8; padded bits are 0.
- If the result is 64: emit the word and set cnt=0.
- Already aligned: no-op.

Flush (same edge, after code and align):
- Enter S_FLUSH.
- S_FLUSH: wait until out_pending=0. Then, if cnt>0, load out_word=acc (zero-padded), set out_pending, cnt=0, acc=0. Go to S_DONE.
- S_DONE: wait until out_pending=0, then pulse flush_done for one cycle and return to S_RUN.
- Flush with cnt=0 and nothing pending: flush_done pulses 2 cycles after acceptance.

Backpressure and staging:
- While out_pending, no new input is accepted, so acc never overflows.
- vid_out is stable while vid_out_full holds.
- One word of staging is sufficient. Peak throughput is one code per cycle, with a one-cycle bubble per emitted word.

Decomposition:
- Package putbits_pkg: WORD_W, CODE_W, LEN_W, MAX_LEN=24, state enum {S_RUN, S_FLUSH, S_DONE}, and a length-saturation function.
- One natural sub-module, putbits_merge (combinational): takes acc, cnt, code, len and align, and produces next acc, next cnt, word_out and word_done. The top level holds the registers, FSM, FIFO handshake and counter.

Test Plan:
1. Reset, then release → bits_ready=1, vid_out_wr_en=0, word_count=0; assert rst mid-word → cnt=0, no write follows.
2. Eight codes len 8, values 0x00..0x07 → exactly one write, vid_out=0x0001020304050607, word_count=1.
3. Three codes len 24, value 0xABCDEF → write 0xABCDEFABCDEFABCD; then flush → second write 0xEF00000000000000 and a flush_done pulse.
4. bits_in=0xFFFFFF with bits_len=4, then len 31 with 0x000001, then flush → masking and saturation checked: word 0xF000001000000000.
5. Complete a word with vid_out_full=1 for 5 cycles → bits_ready=0, vid_out_wr_en=0, vid_out stable. Then release → exactly one write, bits_ready returns the next cycle.
6. Code 0b101 len 3, align, code 0xFF len 8, then flush → word 0xA0FF000000000000. With clk_en=0 for 3 cycles mid-sequence, the result is identical and no extra writes occur.

Source files
------------

// File: rtl/putbits_pkg.sv
// Shared types and constants for the putbits bit packer.
// Codes of up to MAX_LEN bits are packed MSB-first into WORD_W-bit output words.
package putbits_pkg;
   localparam int WORD_W  = 64;
   localparam int CODE_W  = 24;
   localparam int LEN_W   = 5;
   localparam int MAX_LEN = 24;
   localparam int CNT_W   = 6;

   typedef enum logic [1:0] {
      S_RUN,
      S_FLUSH,
      S_DONE
   } state_e;

   // Lengths 25..31 are treated as full-width codes.
   function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
      return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
   endfunction
endpackage

// File: rtl/putbits_if.sv
// Code-input, control and output-FIFO signals of putbits.
// The slave modport is the packer's view; the master modport is the producer/FIFO view.
interface putbits_if;
   import putbits_pkg::*;

   logic                 clk_en;
   logic [CODE_W-1:0]    bits_in;
   logic [LEN_W-1:0]     bits_len;
   logic                 bits_valid;
   logic                 bits_ready;
   logic                 align;
   logic                 flush;
   logic [WORD_W-1:0]    vid_out;
   logic                 vid_out_wr_en;
   logic                 vid_out_full;
   logic                 flush_done;
   logic [31:0]          word_count;

   modport master (
      output clk_en, bits_in, bits_len, bits_valid, align, flush, vid_out_full,
      input  bits_ready, vid_out, vid_out_wr_en, flush_done, word_count
   );

   modport slave (
      input  clk_en, bits_in, bits_len, bits_valid, align, flush, vid_out_full,
      output bits_ready, vid_out, vid_out_wr_en, flush_done, word_count
   );
endinterface

// File: rtl/putbits_merge.sv
// Combinational merge of one code (plus optional byte alignment) into the accumulator.
// Bits of acc below the fill level are always zero, so alignment only moves cnt.
module putbits_merge
   import putbits_pkg::*;
(
   input  logic [WORD_W-1:0] acc_i,
   input  logic [CNT_W-1:0]  cnt_i,
   input  logic [CODE_W-1:0] code_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              align_i,
   output logic [WORD_W-1:0] acc_o,
   output logic [CNT_W-1:0]  cnt_o,
   output logic [WORD_W-1:0] word_o,
   output logic              word_done_o
);
   logic [CODE_W-1:0]   code_m;
   logic [6:0]          total;
   logic [6:0]          fill;
   logic [6:0]          aligned;
   logic [7:0]          shamt;
   logic [2*WORD_W-1:0] wide;
   logic                done;

   always_comb begin
      code_m  = code_i & ~({CODE_W{1'b1}} << len_i);
      total   = 7'(cnt_i) + 7'(len_i);
      // Code lands just below the current fill level in a double-width window.
      shamt   = 8'd128 - 8'(total);
      wide    = {acc_i, {WORD_W{1'b0}}} | ({{(2*WORD_W-CODE_W){1'b0}}, code_m} << shamt);
      done    = (total >= 7'd64);
      fill    = done ? (total - 7'd64) : total;
      aligned = (fill + 7'd7) & 7'h78;
      word_o  = wide[2*WORD_W-1:WORD_W];
      acc_o   = done ? wide[WORD_W-1:0] : wide[2*WORD_W-1:WORD_W];
      cnt_o   = fill[CNT_W-1:0];
      if (align_i) begin
         if (aligned == 7'd64) begin
            done  = 1'b1;
            acc_o = '0;
            cnt_o = '0;
         end else begin
            cnt_o = aligned[CNT_W-1:0];
         end
      end
      word_done_o = done;
   end
endmodule

// File: rtl/putbits.sv
// Variable-length code packer: holds the accumulator, single-word output staging,
// flush FSM, FIFO write handshake and the written-word counter.
module putbits
   import putbits_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   putbits_if.slave  bus
);
   logic [WORD_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   logic              out_pending_q, out_pending_d;
   state_e            state_q, state_d;
   logic [31:0]       word_count_q, word_count_d;

   logic              bits_ready;
   logic              wr_en;
   logic              flush_done;
   logic              accept;
   logic              idle;
   logic [LEN_W-1:0]  len_eff;
   logic [WORD_W-1:0] m_acc;
   logic [CNT_W-1:0]  m_cnt;
   logic [WORD_W-1:0] m_word;
   logic              m_done;

   assign len_eff = bus.bits_valid ? sat_len(bus.bits_len) : '0;

   putbits_merge u_merge (
      .acc_i       (acc_q),
      .cnt_i       (cnt_q),
      .code_i      (bus.bits_in),
      .len_i       (len_eff),
      .align_i     (bus.align | bus.flush),
      .acc_o       (m_acc),
      .cnt_o       (m_cnt),
      .word_o      (m_word),
      .word_done_o (m_done)
   );

   always_comb begin
      // NOTE: every next-state and output gets its hold/idle value first, so no branch can leave one unassigned and infer a latch.
      acc_d         = acc_q;
      cnt_d         = cnt_q;
      out_word_d    = out_word_q;
      out_pending_d = out_pending_q;
      state_d       = state_q;
      word_count_d  = word_count_q;
      flush_done    = 1'b0;

      idle       = bus.clk_en & ~out_pending_q;
      bits_ready = idle & (state_q == S_RUN);
      wr_en      = bus.clk_en & out_pending_q & ~bus.vid_out_full;
      accept     = bits_ready & (bus.bits_valid | bus.align | bus.flush);

      if (wr_en) begin
         out_pending_d = 1'b0;
         word_count_d  = word_count_q + 32'd1;
      end

      unique case (state_q)
         S_RUN: begin
            if (accept) begin
               acc_d = m_acc;
               cnt_d = m_cnt;
               if (m_done) begin
                  out_word_d    = m_word;
                  out_pending_d = 1'b1;
               end
               if (bus.flush) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (idle) begin
               if (cnt_q != '0) begin
                  out_word_d    = acc_q;
                  out_pending_d = 1'b1;
                  acc_d         = '0;
                  cnt_d         = '0;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (idle) begin
               flush_done = 1'b1;
               state_d    = S_RUN;
            end
         end
         default: state_d = S_RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q         <= '0;
         cnt_q         <= '0;
         out_word_q    <= '0;
         out_pending_q <= 1'b0;
         state_q       <= S_RUN;
         word_count_q  <= '0;
      end else if (bus.clk_en) begin
         acc_q         <= acc_d;
         cnt_q         <= cnt_d;
         out_word_q    <= out_word_d;
         out_pending_q <= out_pending_d;
         state_q       <= state_d;
         word_count_q  <= word_count_d;
      end
   end

   assign bus.bits_ready    = bits_ready;
   assign bus.vid_out       = out_word_q;
   assign bus.vid_out_wr_en = wr_en;
   assign bus.flush_done    = flush_done;
   assign bus.word_count    = word_count_q;
endmodule

// File: tb/tb_putbits.sv
// Self-checking bench for putbits: directed scenarios plus randomized traffic
// compared against a bit-queue reference model of the output stream.
module tb_putbits;
   logic clk = 1'b0;
   logic rst = 1'b1;

   putbits_if bus();

   putbits dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the output stream as a plain queue of bits.
   bit          mq[$];
   logic [63:0] exp_q[$];
   int          model_words = 0;
   int          flush_pend  = 0;

   int          words_seen = 0;
   int          flush_seen = 0;
   logic [63:0] last_word  = '0;
   bit          rand_bp    = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_emit();
      logic [63:0] w;
      while (mq.size() >= 64) begin
         for (int i = 63; i >= 0; i--) w[i] = mq.pop_front();
         exp_q.push_back(w);
         model_words++;
      end
   endfunction

   function automatic void model_code(input logic [23:0] v, input int len);
      int l = (len > 24) ? 24 : len;
      for (int i = l - 1; i >= 0; i--) mq.push_back(v[i]);
      model_emit();
   endfunction

   function automatic void model_align();
      while (mq.size() % 8 != 0) mq.push_back(1'b0);
      model_emit();
   endfunction

   function automatic void model_flush();
      model_align();
      if (mq.size() > 0) while (mq.size() < 64) mq.push_back(1'b0);
      model_emit();
      flush_pend++;
   endfunction

   // Output monitor: a write happens at the next edge whenever wr_en is high here.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.vid_out_wr_en) begin
            chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("vid_out", bus.vid_out, exp_q.pop_front());
            chk("wr_while_full", 64'(bus.vid_out_full), 64'd0);
            last_word = bus.vid_out;
            words_seen++;
         end
         if (bus.flush_done) begin
            chk("flush_done_expected", 64'(flush_pend > 0), 64'd1);
            if (flush_pend > 0) flush_pend--;
            flush_seen++;
         end
      end
   end

   task automatic send(input logic [23:0] v, input logic [4:0] l, input bit vl, input bit al, input bit fl);
      bit done = 1'b0;
      bus.bits_in    = v;
      bus.bits_len   = l;
      bus.bits_valid = vl;
      bus.align      = al;
      bus.flush      = fl;
      for (int c = 0; c < 200 && !done; c++) begin
         if (rand_bp) begin
            bus.vid_out_full = ($urandom_range(3) == 0);
            bus.clk_en       = ($urandom_range(7) != 0);
         end
         @(negedge clk);
         if (bus.bits_ready) begin
            if (vl) model_code(v, int'(l));
            if (al) model_align();
            if (fl) model_flush();
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      chk("send_accepted", 64'(done), 64'd1);
      bus.bits_valid = 1'b0;
      bus.align      = 1'b0;
      bus.flush      = 1'b0;
   endtask

   task automatic wait_words(input string tag, input int n);
      for (int c = 0; c < 100 && words_seen < n; c++) begin
         @(posedge clk);
         #1;
      end
      chk(tag, 64'(words_seen), 64'(n));
   endtask

   task automatic wait_flush(input string tag, input int n);
      for (int c = 0; c < 100 && flush_seen < n; c++) begin
         @(posedge clk);
         #1;
      end
      chk(tag, 64'(flush_seen), 64'(n));
   endtask

   initial begin
      bus.clk_en       = 1'b1;
      bus.bits_in      = '0;
      bus.bits_len     = '0;
      bus.bits_valid   = 1'b0;
      bus.align        = 1'b0;
      bus.flush        = 1'b0;
      bus.vid_out_full = 1'b0;

      // 1. reset state, then a reset in the middle of a word
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(bus.bits_ready), 64'd1);
      chk("rst_wr_en", 64'(bus.vid_out_wr_en), 64'd0);
      chk("rst_word_count", 64'(bus.word_count), 64'd0);
      chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
      chk("rst_vid_out", bus.vid_out, 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) send(24'h5A5A5A, 5'd24, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      mq.delete();
      exp_q.delete();
      model_words = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("midrst_no_write", 64'(bus.vid_out_wr_en), 64'd0);
      end
      chk("midrst_word_count", 64'(bus.word_count), 64'd0);
      @(posedge clk);
      #1;

      // 2. eight byte codes form exactly one word
      for (int i = 0; i < 8; i++) send(24'(i), 5'd8, 1'b1, 1'b0, 1'b0);
      wait_words("t2_writes", 1);
      chk("t2_word", last_word, 64'h0001020304050607);
      @(negedge clk);
      chk("t2_word_count", 64'(bus.word_count), 64'd1);
      @(posedge clk);
      #1;

      // 3. codes crossing a word boundary, then flush of the residue
      for (int i = 0; i < 3; i++) send(24'hABCDEF, 5'd24, 1'b1, 1'b0, 1'b0);
      wait_words("t3_writes_a", 2);
      chk("t3_word_a", last_word, 64'hABCDEFABCDEFABCD);
      send(24'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      wait_flush("t3_flush_done", 1);
      chk("t3_writes_b", 64'(words_seen), 64'd3);
      chk("t3_word_b", last_word, 64'hEF00000000000000);

      // 4. masking of high bits and length saturation
      send(24'hFFFFFF, 5'd4, 1'b1, 1'b0, 1'b0);
      send(24'h000001, 5'd31, 1'b1, 1'b0, 1'b0);
      send(24'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      wait_flush("t4_flush_done", 2);
      chk("t4_word", last_word, 64'hF000001000000000);

      // 5. output backpressure holds the staged word
      bus.vid_out_full = 1'b1;
      for (int i = 0; i < 8; i++) send(24'h10 + 24'(i), 5'd8, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_ready_low", 64'(bus.bits_ready), 64'd0);
         chk("t5_wr_low", 64'(bus.vid_out_wr_en), 64'd0);
         chk("t5_vid_stable", bus.vid_out, 64'h1011121314151617);
         @(posedge clk);
         #1;
      end
      bus.vid_out_full = 1'b0;
      @(negedge clk);
      chk("t5_wr_release", 64'(bus.vid_out_wr_en), 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("t5_ready_back", 64'(bus.bits_ready), 64'd1);
      chk("t5_one_write", 64'(words_seen), 64'd5);
      @(posedge clk);
      #1;

      // 6. align between codes, first without and then with a clock-enable stall
      send(24'h5, 5'd3, 1'b1, 1'b0, 1'b0);
      send(24'h0, 5'd0, 1'b0, 1'b1, 1'b0);
      send(24'hFF, 5'd8, 1'b1, 1'b0, 1'b0);
      send(24'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      wait_flush("t6_flush_a", 3);
      chk("t6_word_a", last_word, 64'hA0FF000000000000);
      send(24'h5, 5'd3, 1'b1, 1'b0, 1'b0);
      bus.clk_en     = 1'b0;
      bus.bits_in    = 24'hFF;
      bus.bits_len   = 5'd8;
      bus.bits_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_stall_ready", 64'(bus.bits_ready), 64'd0);
         chk("t6_stall_wr", 64'(bus.vid_out_wr_en), 64'd0);
         @(posedge clk);
         #1;
      end
      bus.clk_en = 1'b1;
      send(24'h0, 5'd0, 1'b0, 1'b1, 1'b0);
      send(24'hFF, 5'd8, 1'b1, 1'b0, 1'b0);
      send(24'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      wait_flush("t6_flush_b", 4);
      chk("t6_word_b", last_word, 64'hA0FF000000000000);
      chk("t6_writes", 64'(words_seen), 64'd7);

      // flush with nothing buffered: done pulse two cycles after acceptance
      send(24'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("empty_flush_c1", 64'(bus.flush_done), 64'd0);
      @(negedge clk);
      chk("empty_flush_c2", 64'(bus.flush_done), 64'd1);
      chk("empty_flush_nowr", 64'(bus.vid_out_wr_en), 64'd0);
      @(posedge clk);
      #1;

      // randomized traffic with random backpressure and clock-enable gaps
      rand_bp = 1'b1;
      for (int i = 0; i < 400; i++)
         send(24'($urandom), 5'($urandom_range(31)), $urandom_range(3) != 0,
              $urandom_range(9) == 0, $urandom_range(29) == 0);
      rand_bp          = 1'b0;
      bus.vid_out_full = 1'b0;
      bus.clk_en       = 1'b1;
      send(24'h0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 200 && (exp_q.size() != 0 || flush_pend != 0); c++) begin
         @(posedge clk);
         #1;
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      chk("rand_flush_pend", 64'(flush_pend), 64'd0);
      @(negedge clk);
      chk("rand_word_count", 64'(bus.word_count), 64'(model_words));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
